// File: rtl/read_response_pipe_pkg.sv
// Shared widths and response-tag type for the VRF read response pipe.
package read_response_pipe_pkg;

    localparam int VRF_ADDR_W    = 13;
    localparam int READ_SOURCE_W = 4;
    localparam int INSTR_INDEX_W = 3;

    typedef struct packed {
        logic [READ_SOURCE_W-1:0] read_source;
        logic [INSTR_INDEX_W-1:0] instruction_index;
    } resp_tag_t;

    localparam int RESP_TAG_W = $bits(resp_tag_t);

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/read_response_fifo.sv
// Response FIFO with wrapping pointers and an unreset storage array.
module read_response_fifo
    import read_response_pipe_pkg::*;
#(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             do_pop_s;

    assign full_s    = (count_r == FULL_CNT);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign head_data = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    read_response_fifo_chk u_chk (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .full  (full_s)
    );

endmodule

// File: rtl/read_response_fifo_chk.sv
// Run-time check that the response FIFO never receives a write while full.
module read_response_fifo_chk (
    input logic clock,
    input logic reset,
    input logic push,
    input logic full
);

    // Credits should make this unreachable; a hit means the credit loop is broken.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(push && full))
                else $error("read_response_fifo: write attempted while full");
        end
    end

endmodule

// File: rtl/read_response_pipe.sv
// VRF read response pipe: credit-gated request issue, fixed-latency tag
// pipeline and an in-order response FIFO.
module read_response_pipe
    import read_response_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_vs,
    input  logic [7:0]               req_offset,
    input  logic [READ_SOURCE_W-1:0] req_readSource,
    input  logic [INSTR_INDEX_W-1:0] req_instructionIndex,
    output logic                     vrf_read_valid,
    output logic [VRF_ADDR_W-1:0]    vrf_read_addr,
    input  logic [DATA_W-1:0]        vrf_read_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic [READ_SOURCE_W-1:0] resp_readSource,
    output logic [INSTR_INDEX_W-1:0] resp_instructionIndex
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + RESP_TAG_W;

    logic [CNT_W-1:0]        credits_r;
    logic [READ_LATENCY-1:0] stage_valid_r;
    resp_tag_t               stage_tag_r [READ_LATENCY];
    resp_tag_t               req_tag_s;
    resp_tag_t               head_tag_s;
    logic [ENTRY_W-1:0]      push_entry_s;
    logic [ENTRY_W-1:0]      head_entry_s;
    logic                    accept_s;
    logic                    fire_s;
    logic                    push_s;
    logic                    fifo_empty_s;

    // Credits cover both in-flight reads and queued responses, so the FIFO can never overflow.
    assign req_ready      = ~reset & (credits_r < CNT_W'(DEPTH));
    assign accept_s       = req_valid & req_ready;
    assign vrf_read_valid = accept_s;
    assign vrf_read_addr  = {req_vs, req_offset};

    assign resp_valid = ~reset & ~fifo_empty_s;
    assign fire_s     = resp_valid & resp_ready;

    assign req_tag_s.read_source       = req_readSource;
    assign req_tag_s.instruction_index = req_instructionIndex;

    assign push_s       = stage_valid_r[READ_LATENCY-1];
    assign push_entry_s = {vrf_read_data, stage_tag_r[READ_LATENCY-1]};

    assign {resp_data, head_tag_s} = head_entry_s;
    assign resp_readSource         = head_tag_s.read_source;
    assign resp_instructionIndex   = head_tag_s.instruction_index;

    // Outstanding-request counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            credits_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, fire_s})
                2'b10:   credits_r <= credits_r + CNT_W'(1);
                2'b01:   credits_r <= credits_r - CNT_W'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Valid bits track reads in flight; clearing them drops any late VRF data.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid_r <= {READ_LATENCY{1'b0}};
        end else begin
            stage_valid_r[0] <= accept_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid_r[i] <= stage_valid_r[i-1];
            end
        end
    end

    // Tag payload shifts alongside the valid bits; only meaningful where valid.
    always_ff @(posedge clock) begin
        stage_tag_r[0] <= req_tag_s;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_tag_r[i] <= stage_tag_r[i-1];
        end
    end

    read_response_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (fire_s),
        .head_data (head_entry_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_read_response_pipe.sv
// Bench for read_response_pipe: default build and a READ_LATENCY=1/DEPTH=2 build
// driven in lockstep, each checked against a queue-based reference model.
module tb_read_response_pipe;

    localparam int LAT_A = 2;
    localparam int DEP_A = 4;
    localparam int LAT_B = 1;
    localparam int DEP_B = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [4:0]  req_vs;
    logic [7:0]  req_offset;
    logic [3:0]  req_src;
    logic [2:0]  req_idx;
    logic        resp_ready;

    logic        req_ready_a, vrf_valid_a, resp_valid_a;
    logic [12:0] vrf_addr_a;
    logic [31:0] vrf_data_a, resp_data_a;
    logic [3:0]  resp_src_a;
    logic [2:0]  resp_idx_a;

    logic        req_ready_b, vrf_valid_b, resp_valid_b;
    logic [12:0] vrf_addr_b;
    logic [31:0] vrf_data_b, resp_data_b;
    logic [3:0]  resp_src_b;
    logic [2:0]  resp_idx_b;

    always #5 clock = ~clock;

    read_response_pipe #(.DATA_W(32), .READ_LATENCY(LAT_A), .DEPTH(DEP_A)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_a),
        .req_vs(req_vs), .req_offset(req_offset),
        .req_readSource(req_src), .req_instructionIndex(req_idx),
        .vrf_read_valid(vrf_valid_a), .vrf_read_addr(vrf_addr_a), .vrf_read_data(vrf_data_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_data(resp_data_a), .resp_readSource(resp_src_a), .resp_instructionIndex(resp_idx_a)
    );

    read_response_pipe #(.DATA_W(32), .READ_LATENCY(LAT_B), .DEPTH(DEP_B)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_b),
        .req_vs(req_vs), .req_offset(req_offset),
        .req_readSource(req_src), .req_instructionIndex(req_idx),
        .vrf_read_valid(vrf_valid_b), .vrf_read_addr(vrf_addr_b), .vrf_read_data(vrf_data_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_data(resp_data_b), .resp_readSource(resp_src_b), .resp_instructionIndex(resp_idx_b)
    );

    // Reference model: an accepted request becomes a queue entry that is
    // visible at the response port LAT+1 cycles later and leaves on a fire.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  src;
        logic [2:0]  idx;
        int          avail;
    } ent_t;

    ent_t        q_a[$];
    ent_t        q_b[$];
    logic [31:0] sched_a [8];
    logic [31:0] sched_b [8];

    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int acc_a     = 0;
    int rv_seen_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic rv, input logic rr,
                        input logic [4:0] vs, input logic [7:0] off,
                        input logic [3:0] src, input logic [2:0] idx);
        logic        rdy_a, rdy_b, rvx_a, rvx_b;
        logic [31:0] d;
        ent_t        e;
        @(negedge clock);
        reset      = rst;
        req_valid  = rv;
        resp_ready = rr;
        req_vs     = vs;
        req_offset = off;
        req_src    = src;
        req_idx    = idx;
        vrf_data_a = sched_a[cyc % 8];
        vrf_data_b = sched_b[cyc % 8];
        #1;
        rdy_a = !rst && (q_a.size() < DEP_A);
        rdy_b = !rst && (q_b.size() < DEP_B);
        rvx_a = !rst && (q_a.size() > 0) && (q_a[0].avail <= cyc);
        rvx_b = !rst && (q_b.size() > 0) && (q_b[0].avail <= cyc);

        chk("a.req_ready", {31'd0, req_ready_a}, {31'd0, rdy_a});
        chk("a.vrf_read_valid", {31'd0, vrf_valid_a}, {31'd0, rv && rdy_a});
        if (rv && rdy_a) chk("a.vrf_read_addr", {19'd0, vrf_addr_a}, {19'd0, vs, off});
        chk("a.resp_valid", {31'd0, resp_valid_a}, {31'd0, rvx_a});
        if (rvx_a) begin
            chk("a.resp_data", resp_data_a, q_a[0].data);
            chk("a.resp_readSource", {28'd0, resp_src_a}, {28'd0, q_a[0].src});
            chk("a.resp_instructionIndex", {29'd0, resp_idx_a}, {29'd0, q_a[0].idx});
        end

        chk("b.req_ready", {31'd0, req_ready_b}, {31'd0, rdy_b});
        chk("b.vrf_read_valid", {31'd0, vrf_valid_b}, {31'd0, rv && rdy_b});
        if (rv && rdy_b) chk("b.vrf_read_addr", {19'd0, vrf_addr_b}, {19'd0, vs, off});
        chk("b.resp_valid", {31'd0, resp_valid_b}, {31'd0, rvx_b});
        if (rvx_b) begin
            chk("b.resp_data", resp_data_b, q_b[0].data);
            chk("b.resp_readSource", {28'd0, resp_src_b}, {28'd0, q_b[0].src});
            chk("b.resp_instructionIndex", {29'd0, resp_idx_b}, {29'd0, q_b[0].idx});
        end

        if (vrf_valid_a === 1'b1) acc_a++;
        if (resp_valid_a === 1'b1) rv_seen_a++;

        @(posedge clock);
        sched_a[cyc % 8] = $urandom;
        sched_b[cyc % 8] = $urandom;
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (rvx_a && rr) e = q_a.pop_front();
            if (rvx_b && rr) e = q_b.pop_front();
            if (rv && rdy_a) begin
                d = $urandom;
                sched_a[(cyc + LAT_A) % 8] = d;
                e.data = d; e.src = src; e.idx = idx; e.avail = cyc + LAT_A + 1;
                q_a.push_back(e);
            end
            if (rv && rdy_b) begin
                d = $urandom;
                sched_b[(cyc + LAT_B) % 8] = d;
                e.data = d; e.src = src; e.idx = idx; e.avail = cyc + LAT_B + 1;
                q_b.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic rtick(input logic rst, input logic rv, input logic rr);
        tick(rst, rv, rr, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom));
    endtask

    initial begin
        int acc0;
        int rv0;
        for (int i = 0; i < 8; i++) begin
            sched_a[i] = $urandom;
            sched_b[i] = $urandom;
        end
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_vs = 5'd0; req_offset = 8'd0; req_src = 4'd0; req_idx = 3'd0;
        vrf_data_a = 32'd0; vrf_data_b = 32'd0;

        // Reset held with a request pending: nothing may be strobed or returned.
        rtick(1'b1, 1'b1, 1'b1);
        rtick(1'b1, 1'b1, 1'b1);
        rtick(1'b0, 1'b0, 1'b1);

        // Single read with the documented tags and address.
        tick(1'b0, 1'b1, 1'b1, 5'd3, 8'h10, 4'd5, 3'd2);
        #1 chk("single.addr", {19'd0, vrf_addr_a}, 32'h0000_0310);
        repeat (5) rtick(1'b0, 1'b0, 1'b1);

        // Back-pressure: only DEPTH accepts, then one fire reopens the port.
        acc0 = acc_a;
        repeat (7) rtick(1'b0, 1'b1, 1'b0);
        chk("backpressure.accepts", acc_a - acc0, 32'd4);
        rtick(1'b0, 1'b0, 1'b1);
        rtick(1'b0, 1'b0, 1'b0);
        repeat (8) rtick(1'b0, 1'b0, 1'b1);

        // Steady stream: one accept every cycle for the default build.
        acc0 = acc_a;
        repeat (100) rtick(1'b0, 1'b1, 1'b1);
        chk("stream.accepts", acc_a - acc0, 32'd100);
        repeat (8) rtick(1'b0, 1'b0, 1'b1);

        // Reset with two entries queued and two reads in flight.
        repeat (4) rtick(1'b0, 1'b1, 1'b0);
        rtick(1'b1, 1'b0, 1'b0);
        rv0 = rv_seen_a;
        repeat (6) rtick(1'b0, 1'b0, 1'b1);
        chk("reset.no_late_resp", rv_seen_a - rv0, 32'd0);

        // Random traffic with occasional resets.
        repeat (500) rtick(1'($urandom_range(0, 59) == 0),
                           1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) != 0));
        repeat (10) rtick(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
